speed_ctrl: RTL and testbench
=============================

SPEED_CTRL -- requirements
Module: speed_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 500000, meaning the number of stable synchronized cycles required before a button level is accepted (minimum 2).
REQ-002 The block SHALL have parameter BASE_DIV, default 390625, meaning the tick period in clk cycles at speed 7.
REQ-003 The block SHALL have parameter SPEED_INIT, default 4, meaning the speed value loaded at reset (0..7).
REQ-004 The block SHALL have parameter CNT_W, default 27, meaning the prescaler counter width, with BASE_DIV*128 <= 2^CNT_W.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port btn_up, input, 1 bit: raw asynchronous button, high = pressed, speed increment.
REQ-008 The block SHALL have port btn_dn, input, 1 bit: raw asynchronous button, high = pressed, speed decrement.
REQ-009 The block SHALL have port btn_pause, input, 1 bit: raw asynchronous button, high = pressed, pause toggle.
REQ-010 The block SHALL have port ce, output, 1 bit: registered one-cycle enable pulse that drives the downstream running-light en input.
REQ-011 The block SHALL have port speed, output, 3 bits: current speed, 0 = slowest and 7 = fastest.
REQ-012 The block SHALL have port paused, output, 1 bit: high while tick generation is halted.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, giving sync = raw delayed by 2 clocks.
REQ-014 For each button, a debounce counter SHALL increment every cycle in which sync != deb, and clear in any cycle in which sync == deb.
REQ-015 For each button, deb SHALL toggle and the debounce counter SHALL clear at the edge where the counter == DEB_CYCLES-1 and sync != deb.
REQ-016 Each button's press event SHALL be deb & ~deb_prev, where deb_prev is deb registered once; only rising edges are events.
REQ-017 Overall latency SHALL be: a raw level held stable from edge 0 updates speed/paused at edge DEB_CYCLES+3.
REQ-018 Glitches shorter than DEB_CYCLES synchronized cycles SHALL produce no event.
REQ-019 An up event alone SHALL set speed <= speed+1, saturating at 7.
REQ-020 A down event alone SHALL set speed <= speed-1, saturating at 0.
REQ-021 Up and down events in the same cycle SHALL leave speed unchanged.
REQ-022 A pause event SHALL toggle paused.
REQ-023 Tick period SHALL be P = BASE_DIV << (7 - speed) clk cycles; the shift is computed at CNT_W width, with no overflow permitted by REQ-004.
REQ-024 While not paused, the prescaler cnt SHALL increment by 1 per cycle.
REQ-025 At the edge where cnt == P-1 (not paused), the block SHALL set cnt <= 0 and ce <= 1; at all other edges it SHALL set ce <= 0.
REQ-026 ce SHALL never be high for two consecutive cycles when P >= 2.
REQ-027 While paused, cnt SHALL hold its value and ce SHALL be 0; on unpause, counting SHALL resume from the held cnt.
REQ-028 At the edge where speed actually changes value, the block SHALL set cnt <= 0 and ce <= 0.
REQ-029 A saturated, no-op, or cancelled (REQ-021) speed request SHALL not restart cnt.
REQ-030 A pause toggle and a speed change in the same cycle SHALL both take effect, with cnt <= 0.

Reset
REQ-031 While rst is high at an edge, the block SHALL set cnt=0, ce=0, speed=SPEED_INIT, paused=0, all sync/deb/deb_prev=0, and all debounce counters=0.
REQ-032 rst SHALL override all other activity, including mid-debounce and mid-period.
REQ-033 The first ce after rst release SHALL be high in the cycle following the P-th edge after release.
REQ-034 A button held through reset SHALL be debounced afresh and SHALL generate one event DEB_CYCLES+3 edges after release.

Verification (DEB_CYCLES=4, BASE_DIV=2, SPEED_INIT=4)
REQ-035 The bench SHALL cover: reset, no buttons -> speed=4, paused=0, ce pulses every 16 cycles, first ce after edge 16.
REQ-036 The bench SHALL cover: btn_up held 20 cycles, three separate times -> speed 5, 6, 7; after the 7 update, ce period = 2 (pulse every other cycle); a fourth press leaves speed=7 with no cnt restart.
REQ-037 The bench SHALL cover: btn_dn high for 3 cycles then low -> no event, speed unchanged; a 1-cycle bounce inside a 10-cycle hold -> exactly one event.
REQ-038 The bench SHALL cover: btn_up and btn_dn rising on the same cycle and held -> speed unchanged, ce phase undisturbed.
REQ-039 The bench SHALL cover: btn_pause press at cnt=9 (speed 4) -> paused=1, ce=0 indefinitely, cnt frozen at its value; second press -> ce after the remaining 16-cnt cycles.
REQ-040 The bench SHALL cover: rst asserted mid-debounce and mid-period -> all outputs at reset values next cycle, no spurious ce or event after release.

Source files
------------

// File: rtl/speed_ctrl.sv
// ---------------------------------------------------------------------------
// speed_ctrl
//   Speed and pause controller for a running-light display. The three
//   pushbuttons are synchronized and debounced. Each rising edge of a
//   debounced level becomes a one-cycle press event. A prescaler then turns
//   the current speed into a periodic one-cycle enable pulse (ce).
//
// Parameters
//   DEB_CYCLES : stable synchronized cycles before a button level is accepted (>= 2)
//   BASE_DIV   : tick period in clk cycles at speed 7
//   SPEED_INIT : speed loaded at reset (0..7)
//   CNT_W      : prescaler width; BASE_DIV*128 must fit in 2**CNT_W
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   btn_up     : raw button, high = pressed, increments speed
//   btn_dn     : raw button, high = pressed, decrements speed
//   btn_pause  : raw button, high = pressed, toggles pause
//   ce         : registered one-cycle enable pulse for the running light
//   speed      : current speed, 0 = slowest, 7 = fastest
//   paused     : high while tick generation is halted
// ---------------------------------------------------------------------------
module speed_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int BASE_DIV   = 390625,
  parameter int SPEED_INIT = 4,
  parameter int CNT_W      = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_pause,
  output logic       ce,
  output logic [2:0] speed,
  output logic       paused
);

  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [CNT_W-1:0] BASE     = CNT_W'(BASE_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Button order: 0 = up, 1 = down, 2 = pause.
  logic [2:0] btn_raw;
  logic [2:0] evt;

  assign btn_raw = {btn_pause, btn_dn, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             deb_reg;
      logic             deb_prev_reg;
      logic [DEB_W-1:0] deb_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          deb_reg      <= 1'b0;
          deb_prev_reg <= 1'b0;
          deb_cnt_reg  <= '0;
        end else begin
          sync1_reg    <= btn_raw[gi];
          sync2_reg    <= sync1_reg;
          deb_prev_reg <= deb_reg;
          // Any cycle where sync agrees with the accepted level restarts
          // the stability window. Short glitches therefore never complete it.
          if (sync2_reg == deb_reg) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            deb_reg     <= sync2_reg;
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + DEB_ONE;
          end
        end
      end

      // Only presses (rising edges of the accepted level) are events.
      assign evt[gi] = deb_reg & ~deb_prev_reg;
    end
  endgenerate

  logic [2:0]       speed_reg;
  logic [2:0]       speed_next;
  logic             paused_reg;
  logic             paused_next;
  logic             ce_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] period;

  // Each step down in speed doubles the tick period.
  assign period = BASE << (3'd7 - speed_reg);

  always_comb begin
    speed_next  = speed_reg;
    paused_next = paused_reg ^ evt[2];
    // Simultaneous up and down cancel. Requests at the rails are ignored.
    if (evt[0] && !evt[1] && speed_reg != 3'd7) begin
      speed_next = speed_reg + 3'd1;
    end else if (evt[1] && !evt[0] && speed_reg != 3'd0) begin
      speed_next = speed_reg - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      speed_reg  <= 3'(SPEED_INIT);
      paused_reg <= 1'b0;
      cnt_reg    <= '0;
      ce_reg     <= 1'b0;
    end else begin
      speed_reg  <= speed_next;
      paused_reg <= paused_next;
      if (speed_next != speed_reg) begin
        // A real speed change restarts the period so the new rate takes
        // effect from a clean phase. This also covers a pause toggle in the same cycle.
        cnt_reg <= '0;
        ce_reg  <= 1'b0;
      end else if (paused_reg) begin
        // Hold the phase so counting resumes where it stopped.
        ce_reg <= 1'b0;
      end else if (cnt_reg == period - CNT_ONE) begin
        cnt_reg <= '0;
        ce_reg  <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + CNT_ONE;
        ce_reg  <= 1'b0;
      end
    end
  end

  assign ce     = ce_reg;
  assign speed  = speed_reg;
  assign paused = paused_reg;

endmodule

// File: tb/tb_speed_ctrl.sv
// ---------------------------------------------------------------------------
// tb_speed_ctrl
//   Directed scenarios followed by randomized button activity. Every cycle,
//   ce, speed and paused are compared with a behavioural reference model.
//   Directed scenarios also check fixed expected values (speeds, ce timing).
// ---------------------------------------------------------------------------
module tb_speed_ctrl;

  localparam int DEB  = 4;
  localparam int BASE = 2;
  localparam int INIT = 4;
  localparam int CW   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic       btn_pause = 1'b0;
  logic       ce;
  logic [2:0] speed;
  logic       paused;

  speed_ctrl #(
    .DEB_CYCLES(DEB),
    .BASE_DIV  (BASE),
    .SPEED_INIT(INIT),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .btn_pause(btn_pause),
    .ce       (ce),
    .speed    (speed),
    .paused   (paused)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int m_s1[3];
  int m_s2[3];
  int m_acc[3];
  int m_prev[3];
  int m_run[3];
  int m_speed  = INIT;
  int m_paused = 0;
  int m_phase  = 0;
  int m_ce     = 0;

  int cyc = 0;
  int ce_q[$];
  int unp_cyc = -1;
  int prev_paused = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // The accepted button level flips once the synchronized input has disagreed
  // with it for DEB consecutive cycles. The tick period is BASE * 2^(7-speed).
  task automatic model_update(input int r, input int u, input int d, input int p);
    int ev[3];
    int rawv[3];
    int nsp;
    int per;
    if (r != 0) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_prev[b] = 0; m_run[b] = 0;
      end
      m_speed = INIT; m_paused = 0; m_phase = 0; m_ce = 0;
      return;
    end
    rawv[0] = u; rawv[1] = d; rawv[2] = p;
    for (int b = 0; b < 3; b++) begin
      ev[b] = (m_acc[b] == 1 && m_prev[b] == 0) ? 1 : 0;
      m_prev[b] = m_acc[b];
      if (m_s2[b] != m_acc[b]) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] == DEB) begin
          m_acc[b] = 1 - m_acc[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = rawv[b];
    end
    nsp = m_speed + ev[0] - ev[1];
    if (nsp > 7) nsp = 7;
    if (nsp < 0) nsp = 0;
    per = BASE * (1 << (7 - m_speed));
    if (nsp != m_speed) begin
      m_phase = 0; m_ce = 0;
    end else if (m_paused != 0) begin
      m_ce = 0;
    end else if (m_phase == per - 1) begin
      m_phase = 0; m_ce = 1;
    end else begin
      m_phase = m_phase + 1; m_ce = 0;
    end
    if (ev[2] != 0) m_paused = 1 - m_paused;
    m_speed = nsp;
  endtask

  task automatic step(input int r, input int u, input int d, input int p);
    rst = (r != 0); btn_up = (u != 0); btn_dn = (d != 0); btn_pause = (p != 0);
    @(posedge clk);
    model_update(r, u, d, p);
    #1;
    if (r != 0) begin
      cyc = 0;
      ce_q.delete();
    end else begin
      cyc = cyc + 1;
      if (ce === 1'b1) ce_q.push_back(cyc);
    end
    if (prev_paused == 1 && paused === 1'b0) unp_cyc = cyc;
    prev_paused = (paused === 1'b1) ? 1 : 0;
    chk("ce", ce, m_ce);
    chk("speed", speed, m_speed);
    chk("paused", paused, m_paused);
  endtask

  task automatic run(input int n, input int r, input int u, input int d, input int p);
    for (int i = 0; i < n; i++) step(r, u, d, p);
  endtask

  function automatic int ce_at(input int i);
    return (ce_q.size() > i) ? ce_q[i] : -1;
  endfunction

  function automatic int last_gap();
    return (ce_q.size() >= 2) ? ce_q[ce_q.size()-1] - ce_q[ce_q.size()-2] : -1;
  endfunction

  function automatic int first_ce_after(input int c);
    foreach (ce_q[i]) if (ce_q[i] > c) return ce_q[i];
    return -1;
  endfunction

  int n0;
  int ru, rd, rp, rr;

  initial begin
    // Reset with no buttons pressed
    run(3, 1, 0, 0, 0);
    chk("rst_speed", speed, 4);
    chk("rst_paused", paused, 0);
    chk("rst_ce", ce, 0);
    run(40, 0, 0, 0, 0);
    chk("first_ce_cycle", ce_at(0), 16);
    chk("second_ce_cycle", ce_at(1), 32);

    // Three separate up presses: 5, 6, 7
    for (int k = 0; k < 3; k++) begin
      run(20, 0, 1, 0, 0);
      run(20, 0, 0, 0, 0);
      chk("up_press_speed", speed, 5 + k);
    end
    chk("speed7_gap", last_gap(), 2);

    // Press at saturation: no change and no phase restart
    n0 = ce_q.size();
    run(20, 0, 1, 0, 0);
    run(20, 0, 0, 0, 0);
    chk("sat_up_speed", speed, 7);
    chk("sat_up_ce_count", ce_q.size() - n0, 20);

    // Glitch shorter than the debounce window
    run(3, 0, 0, 1, 0);
    run(20, 0, 0, 0, 0);
    chk("glitch_speed", speed, 7);

    // One-cycle bounce inside a 10-cycle hold produces exactly one event
    run(2, 0, 0, 1, 0);
    run(1, 0, 0, 0, 0);
    run(7, 0, 0, 1, 0);
    run(20, 0, 0, 0, 0);
    chk("bounce_speed", speed, 6);

    // Up and down together cancel
    run(20, 0, 1, 1, 0);
    run(20, 0, 0, 0, 0);
    chk("cancel_speed", speed, 6);

    // Pause at phase 9 with speed 4, then resume
    run(2, 1, 0, 0, 0);
    run(2, 0, 0, 0, 0);
    run(10, 0, 0, 0, 1);
    chk("pause_on", paused, 1);
    n0 = ce_q.size();
    run(30, 0, 0, 0, 0);
    chk("paused_no_ce", ce_q.size() - n0, 0);
    chk("still_paused", paused, 1);
    unp_cyc = -1;
    run(10, 0, 0, 0, 1);
    run(20, 0, 0, 0, 0);
    chk("pause_off", paused, 0);
    chk("resume_latency", first_ce_after(unp_cyc) - unp_cyc, 7);

    // Reset mid-debounce and mid-period
    run(3, 0, 1, 0, 0);
    run(1, 1, 0, 0, 0);
    chk("midrst_speed", speed, 4);
    chk("midrst_paused", paused, 0);
    chk("midrst_ce", ce, 0);
    run(30, 0, 0, 0, 0);
    chk("post_rst_speed", speed, 4);
    chk("post_rst_first_ce", ce_at(0), 16);

    // Button held through reset yields one event DEB+3 edges after release
    run(2, 1, 1, 0, 0);
    run(6, 0, 1, 0, 0);
    chk("held_rst_before", speed, 4);
    run(1, 0, 1, 0, 0);
    chk("held_rst_event", speed, 5);
    run(20, 0, 0, 0, 0);

    // Walk down to the lower rail
    for (int k = 0; k < 7; k++) begin
      run(8, 0, 0, 1, 0);
      run(8, 0, 0, 0, 0);
      chk("dn_walk_speed", speed, (4 - k > 0) ? 4 - k : 0);
    end
    run(300, 0, 0, 0, 0);

    // Randomized button levels with occasional reset
    ru = 0; rd = 0; rp = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) ru = 1 - ru;
      if ($urandom_range(0, 9) == 0) rd = 1 - rd;
      if ($urandom_range(0, 14) == 0) rp = 1 - rp;
      rr = ($urandom_range(0, 399) == 0) ? 1 : 0;
      step(rr, ru, rd, rp);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
